// File: rtl/edge_trig_pkg.sv
// Shared definitions for the edge trigger controller: state encoding
// (also decoded by the register bank for state_o readback) and default widths.
package edge_trig_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int TCNT_W_DEF = 32;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_PRE     = 3'd1;
    localparam logic [2:0] ENC_ARMED   = 3'd2;
    localparam logic [2:0] ENC_QUAL    = 3'd3;
    localparam logic [2:0] ENC_HOLDOFF = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ENC_IDLE,
        PRE     = ENC_PRE,
        ARMED   = ENC_ARMED,
        QUAL    = ENC_QUAL,
        HOLDOFF = ENC_HOLDOFF
    } state_t;

endpackage

// File: rtl/edge_trig_qual.sv
// Input register and qualification counter. sig_q_o is the event line
// normalised so that 1 means "active level". hit_o is a combinational strobe
// that is high on the cycle whose clock edge completes qual_len active samples.
module edge_trig_qual
    import edge_trig_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             sig_i,
    input  logic             pol_i,
    input  logic [CNT_W-1:0] qual_len_i,
    input  logic             run_i,
    output logic             sig_q_o,
    output logic             hit_o
);

    logic             sig_q;
    logic [CNT_W-1:0] qcnt_q;
    logic [CNT_W-1:0] qcnt_d;
    logic [CNT_W-1:0] qcnt_inc;
    logic [CNT_W-1:0] qual_eff;

    // A programmed length of zero behaves like a single required sample.
    assign qual_eff = (qual_len_i == '0) ? CNT_W'(1) : qual_len_i;
    assign qcnt_inc = qcnt_q + CNT_W'(1);
    assign hit_o    = run_i && sig_q && (qcnt_inc == qual_eff);
    assign sig_q_o  = sig_q;

    // Register the event line once, folding in polarity so 1 = active.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i ^ pol_i ^ 1'b1;
        end
    end

    // Count consecutive active samples; any gap, a hit or leaving ARMED/QUAL restarts at zero.
    always_comb begin
        qcnt_d = '0;
        if (run_i && sig_q && !hit_o) begin
            qcnt_d = qcnt_inc;
        end
    end

    // Qualification counter register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            qcnt_q <= '0;
        end else begin
            qcnt_q <= qcnt_d;
        end
    end

endmodule

// File: rtl/edge_trig_ctrl.sv
// Re-armable qualified edge trigger: arm, wait for the inactive level, qualify
// a run of active samples, pulse trig_o, then holdoff/re-arm or stop.
module edge_trig_ctrl
    import edge_trig_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TCNT_W = TCNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              sig_i,
    input  logic              pol_i,
    input  logic [CNT_W-1:0]  qual_len_i,
    input  logic [CNT_W-1:0]  holdoff_i,
    input  logic              mode_i,
    input  logic              arm_i,
    input  logic              disarm_i,
    input  logic              clr_cnt_i,
    output logic              trig_o,
    output logic              armed_o,
    output logic [2:0]        state_o,
    output logic [TCNT_W-1:0] trig_cnt_o
);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  qual_q;
    logic [CNT_W-1:0]  hold_q;
    logic              mode_q;
    logic [CNT_W-1:0]  hcnt_q;
    logic [CNT_W-1:0]  hcnt_d;
    logic [CNT_W-1:0]  hcnt_inc;
    logic              trig_q;
    logic              trig_d;
    logic [TCNT_W-1:0] tcnt_q;
    logic [TCNT_W-1:0] tcnt_d;
    logic [TCNT_W-1:0] tcnt_base;
    logic              cfg_load;
    logic              run;
    logic              sig_q;
    logic              hit;

    // Qualification only runs while looking for a trigger and not being disarmed.
    assign run      = ((state_q == ARMED) || (state_q == QUAL)) && !disarm_i;
    assign hcnt_inc = hcnt_q + CNT_W'(1);

    edge_trig_qual #(
        .CNT_W (CNT_W)
    ) u_qual (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .sig_i      (sig_i),
        .pol_i      (pol_i),
        .qual_len_i (qual_q),
        .run_i      (run),
        .sig_q_o    (sig_q),
        .hit_o      (hit)
    );

    // Next-state logic; disarm overrides everything, arm only matters in IDLE.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = '0;
        trig_d   = 1'b0;
        cfg_load = 1'b0;
        if (disarm_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm_i) begin
                        state_d  = PRE;
                        cfg_load = 1'b1;
                    end
                end
                PRE: begin
                    if (!sig_q) begin
                        state_d = ARMED;
                    end
                end
                ARMED, QUAL: begin
                    if (hit) begin
                        trig_d = 1'b1;
                        if (!mode_q) begin
                            state_d = IDLE;
                        end else if (hold_q != '0) begin
                            state_d = HOLDOFF;
                        end else begin
                            state_d = PRE;
                        end
                    end else if (sig_q) begin
                        state_d = QUAL;
                    end else begin
                        state_d = ARMED;
                    end
                end
                HOLDOFF: begin
                    if (hcnt_inc == hold_q) begin
                        state_d = PRE;
                    end else begin
                        hcnt_d = hcnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Trigger event counter: clear first, then a same-edge trigger still counts; saturates.
    always_comb begin
        tcnt_base = clr_cnt_i ? '0 : tcnt_q;
        tcnt_d    = tcnt_base;
        if (trig_d && !(&tcnt_base)) begin
            tcnt_d = tcnt_base + TCNT_W'(1);
        end
    end

    // State, holdoff counter, trigger pulse and event counter registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            trig_q  <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            trig_q  <= trig_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Configuration snapshot taken only when an arm request is accepted.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            qual_q <= '0;
            hold_q <= '0;
            mode_q <= 1'b0;
        end else if (cfg_load) begin
            qual_q <= qual_len_i;
            hold_q <= holdoff_i;
            mode_q <= mode_i;
        end
    end

    assign trig_o     = trig_q;
    assign armed_o    = (state_q != IDLE);
    assign state_o    = state_q;
    assign trig_cnt_o = tcnt_q;

endmodule

// File: tb/tb_edge_trig_ctrl.sv
// Directed bench for edge_trig_ctrl: a vector table for the short boundary
// cases, followed by hand-written multi-cycle sequences with known pulse times.
module tb_edge_trig_ctrl;
    import edge_trig_pkg::*;

    localparam int CNT_W  = 16;
    localparam int TCNT_W = 32;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              sig_i;
    logic              pol_i;
    logic [CNT_W-1:0]  qual_len_i;
    logic [CNT_W-1:0]  holdoff_i;
    logic              mode_i;
    logic              arm_i;
    logic              disarm_i;
    logic              clr_cnt_i;
    logic              trig_o;
    logic              armed_o;
    logic [2:0]        state_o;
    logic [TCNT_W-1:0] trig_cnt_o;
    logic              trig4;
    logic              armed4;
    logic [2:0]        state4;
    logic [3:0]        cnt4;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        sig;
        logic        arm;
        logic        disarm;
        logic        clr;
        logic [15:0] qual;
        logic        mode;
        logic        expTrig;
        logic        expArmed;
        logic [2:0]  expState;
        int          expCnt;
    } vec_t;

    vec_t tbl[27];

    edge_trig_ctrl #(.CNT_W(CNT_W), .TCNT_W(TCNT_W)) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .sig_i(sig_i), .pol_i(pol_i),
        .qual_len_i(qual_len_i), .holdoff_i(holdoff_i), .mode_i(mode_i),
        .arm_i(arm_i), .disarm_i(disarm_i), .clr_cnt_i(clr_cnt_i),
        .trig_o(trig_o), .armed_o(armed_o), .state_o(state_o), .trig_cnt_o(trig_cnt_o)
    );

    edge_trig_ctrl #(.CNT_W(CNT_W), .TCNT_W(4)) u_dut4 (
        .clk_i(clk_i), .rstn_i(rstn_i), .sig_i(sig_i), .pol_i(pol_i),
        .qual_len_i(qual_len_i), .holdoff_i(holdoff_i), .mode_i(mode_i),
        .arm_i(arm_i), .disarm_i(disarm_i), .clr_cnt_i(clr_cnt_i),
        .trig_o(trig4), .armed_o(armed4), .state_o(state4), .trig_cnt_o(cnt4)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic s, input logic a, input logic d, input logic c,
                                input int q, input logic m, input logic et, input logic ea,
                                input int es, input int ec);
        vec_t v;
        v.sig = s; v.arm = a; v.disarm = d; v.clr = c;
        v.qual = 16'(q); v.mode = m;
        v.expTrig = et; v.expArmed = ea; v.expState = 3'(es); v.expCnt = ec;
        return v;
    endfunction

    task automatic setConfig(input logic p, input int q, input int h, input logic m);
        pol_i      = p;
        qual_len_i = 16'(q);
        holdoff_i  = 16'(h);
        mode_i     = m;
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic d, input logic c);
        sig_i     = s;
        arm_i     = a;
        disarm_i  = d;
        clr_cnt_i = c;
        @(posedge clk_i);
        #1;
        arm_i     = 1'b0;
        disarm_i  = 1'b0;
        clr_cnt_i = 1'b0;
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string name, input int t, input int a, input int s, input longint c);
        checkOutput({name, "_trig"}, trig_o, t);
        checkOutput({name, "_armed"}, armed_o, a);
        checkOutput({name, "_state"}, state_o, s);
        checkOutput({name, "_cnt"}, trig_cnt_o, c);
    endtask

    // Expected state in the continuous/holdoff sequence, period 16 cycles.
    function automatic int contState(input int k);
        int m;
        m = k % 16;
        if (m == 0) return 2;
        if (m == 1) return 3;
        if (m <= 11) return 4;
        return 1;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int segLen[6];
        int idx;

        rstn_i = 1'b0;
        sig_i = 1'b0; arm_i = 1'b0; disarm_i = 1'b0; clr_cnt_i = 1'b0;
        setConfig(1'b1, 0, 0, 1'b0);

        // Reset state
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkAll("reset", 0, 0, 0, 0);
        rstn_i = 1'b1;

        // Table: qual=0, arm+disarm, disarm on firing edge, clr on trigger, arm ignored, dropout
        tbl[0]  = mk(0,0,1,1, 0,0, 0,0,0,0);
        tbl[1]  = mk(0,1,0,0, 0,0, 0,1,1,0);
        tbl[2]  = mk(1,0,0,0, 0,0, 0,1,2,0);
        tbl[3]  = mk(1,0,0,0, 0,0, 1,0,0,1);
        tbl[4]  = mk(1,0,0,0, 0,0, 0,0,0,1);
        tbl[5]  = mk(1,1,1,0, 0,0, 0,0,0,1);
        tbl[6]  = mk(0,0,0,0, 0,0, 0,0,0,1);
        tbl[7]  = mk(0,1,0,0, 0,0, 0,1,1,1);
        tbl[8]  = mk(0,0,0,0, 0,0, 0,1,2,1);
        tbl[9]  = mk(1,0,0,0, 0,0, 0,1,2,1);
        tbl[10] = mk(1,0,1,0, 0,0, 0,0,0,1);
        tbl[11] = mk(1,0,0,0, 0,0, 0,0,0,1);
        tbl[12] = mk(0,1,0,0, 0,0, 0,1,1,1);
        tbl[13] = mk(1,0,0,0, 0,0, 0,1,2,1);
        tbl[14] = mk(1,0,0,1, 0,0, 1,0,0,1);
        tbl[15] = mk(0,1,0,0, 3,0, 0,1,1,1);
        tbl[16] = mk(0,1,0,0, 0,0, 0,1,2,1);
        tbl[17] = mk(1,1,0,0, 0,0, 0,1,2,1);
        tbl[18] = mk(1,0,0,0, 0,0, 0,1,3,1);
        tbl[19] = mk(1,0,0,0, 0,0, 0,1,3,1);
        tbl[20] = mk(1,0,0,0, 0,0, 1,0,0,2);
        tbl[21] = mk(0,1,0,0, 3,0, 0,1,1,2);
        tbl[22] = mk(1,0,0,0, 0,0, 0,1,2,2);
        tbl[23] = mk(0,0,0,0, 0,0, 0,1,3,2);
        tbl[24] = mk(0,0,0,0, 0,0, 0,1,2,2);
        tbl[25] = mk(0,0,0,0, 0,0, 0,1,2,2);
        tbl[26] = mk(0,0,1,0, 0,0, 0,0,0,2);
        for (int i = 0; i < 27; i++) begin
            qual_len_i = tbl[i].qual;
            mode_i     = tbl[i].mode;
            applyStimulus(tbl[i].sig, tbl[i].arm, tbl[i].disarm, tbl[i].clr);
            checkAll($sformatf("row%0d", i), int'(tbl[i].expTrig), int'(tbl[i].expArmed),
                     int'(tbl[i].expState), longint'(tbl[i].expCnt));
        end

        // Falling edge, single shot, qual=12
        setConfig(1'b0, 12, 0, 1'b0);
        applyStimulus(1, 0, 1, 1);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("fall_armed_state", state_o, 2);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("fall_trig_k%0d", k), trig_o, (k == 12) ? 1 : 0);
        end
        checkAll("fall_end", 0, 0, 0, 1);

        // Glitch rejection: low 5, high 3, low 11, high 3, low 12, high 3
        applyStimulus(1, 0, 1, 1);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        segLen[0] = 5; segLen[1] = 3; segLen[2] = 11;
        segLen[3] = 3; segLen[4] = 12; segLen[5] = 3;
        idx = 0;
        for (int s = 0; s < 6; s++) begin
            for (int j = 0; j < segLen[s]; j++) begin
                applyStimulus((s % 2 == 1) ? 1'b1 : 1'b0, 0, 0, 0);
                checkOutput($sformatf("glitch_trig_i%0d", idx), trig_o, (idx == 34) ? 1 : 0);
                idx++;
            end
        end
        checkAll("glitch_end", 0, 0, 0, 1);

        // Line already active at arm: must see inactive first
        setConfig(1'b0, 4, 0, 1'b0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("active_trig_k%0d", k), trig_o, 0);
        end
        checkOutput("active_hold_state", state_o, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("active_gap_state", state_o, 1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("active_fire_k%0d", k), trig_o, (k == 4) ? 1 : 0);
        end
        checkOutput("active_cnt", trig_cnt_o, 1);

        // Continuous with holdoff=10, qual=2, line low 3 / high 1
        setConfig(1'b0, 2, 10, 1'b1);
        applyStimulus(1, 0, 1, 1);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k <= 50; k++) begin
            applyStimulus((k % 4 == 3) ? 1'b1 : 1'b0, 0, 0, 0);
            checkOutput($sformatf("cont_trig_k%0d", k), trig_o, (k % 16 == 2) ? 1 : 0);
            checkOutput($sformatf("cont_state_k%0d", k), state_o, contState(k));
        end
        checkOutput("cont_cnt", trig_cnt_o, 4);

        // Reset mid-QUAL, then re-arm
        setConfig(1'b0, 12, 0, 1'b0);
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0);
        checkOutput("rstq_pre_state", state_o, 3);
        rstn_i = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkAll("rstq_reset", 0, 0, 0, 0);
        rstn_i = 1'b1;
        for (int k = 0; k < 15; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("rstq_quiet_k%0d", k), trig_o, 0);
        end
        checkOutput("rstq_quiet_state", state_o, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k <= 12; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("rstq_rearm_k%0d", k), trig_o, (k == 12) ? 1 : 0);
        end
        checkOutput("rstq_rearm_cnt", trig_cnt_o, 1);

        // Reset mid-HOLDOFF
        setConfig(1'b0, 1, 10, 1'b1);
        applyStimulus(1, 0, 1, 1);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkAll("rsth_fire", 1, 1, 4, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkAll("rsth_hold", 0, 1, 4, 1);
        rstn_i = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkAll("rsth_reset", 0, 0, 0, 0);
        rstn_i = 1'b1;
        for (int k = 0; k < 15; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("rsth_quiet_k%0d", k), trig_o, 0);
        end
        checkOutput("rsth_quiet_state", state_o, 0);

        // Saturation on the 4-bit counter, then clear on a trigger edge
        setConfig(1'b1, 0, 0, 1'b1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0);
        for (int k = 0; k < 40; k++) begin
            applyStimulus((k % 2 == 0) ? 1'b1 : 1'b0, 0, 0, 0);
            checkOutput($sformatf("sat_trig_k%0d", k), trig_o, k % 2);
            checkOutput($sformatf("sat_trig4_k%0d", k), trig4, k % 2);
            if (k == 27) checkOutput("sat_cnt4_14", cnt4, 14);
            if (k == 29) checkOutput("sat_cnt4_15", cnt4, 15);
        end
        checkOutput("sat_cnt_main", trig_cnt_o, 20);
        checkOutput("sat_cnt4_final", cnt4, 15);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("clr_trig", trig_o, 1);
        checkOutput("clr_cnt_main", trig_cnt_o, 1);
        checkOutput("clr_cnt4", cnt4, 1);
        checkOutput("clr_state4", state4, 1);
        checkOutput("clr_armed4", armed4, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("final_state", state_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_trig_ctrl.md
Name: edge_trig_ctrl

Overview:
Programmable, re-armable trigger controller for qualified edges on a 1-bit event line (comparator output, DIO pin).
- A trigger fires after the line holds its active level for a programmable number of consecutive cycles, preceded by at least one inactive sample.
- It then enforces a programmable holdoff and either re-arms (continuous mode) or stops (single mode).
- It sits between the event source and the scope/ASG trigger inputs, and is configured from the register bank.

Parameters:
CNT_W, 16, width of qualification and holdoff counters
TCNT_W, 32, width of trigger event counter

Ports:
clk_i  in  1  system clock
rstn_i  in  1  synchronous reset, active-low
sig_i  in  1  event line (already synchronous to clk_i)
pol_i  in  1  0: active level low (falling edge), 1: active level high (rising edge)
qual_len_i  in  CNT_W  required consecutive active samples; 0 treated as 1
holdoff_i  in  CNT_W  holdoff cycles after trigger; 0 = none
mode_i  in  1  0: single shot, 1: continuous
arm_i  in  1  one-cycle arm request
disarm_i  in  1  one-cycle disarm request
clr_cnt_i  in  1  one-cycle trigger-counter clear
trig_o  out  1  one-cycle trigger pulse
armed_o  out  1  high in PRE, ARMED, QUAL, HOLDOFF
state_o  out  3  FSM state encoding (debug readback)
trig_cnt_o  out  TCNT_W  triggers fired since clear, saturating

Behaviour:
- Reset: while rstn_i=0, at every clk edge:
  - state=IDLE, trig_o=0, armed_o=0, state_o=0, trig_cnt_o=0.
  - All counters and latched config are cleared.
- Input stage:
  - sig_q <= sig_i ^ pol_i ^ 1, registered once, so sig_q=1 means active.
  - Sampling edge t0 = the edge where sig_i is first sampled active.
- Config latch: qual_len_i, holdoff_i and mode_i are captured on the accepted arm_i edge. Later changes take effect only at the next arm.
- States and encoding: IDLE=0, PRE=1, ARMED=2, QUAL=3, HOLDOFF=4.
- IDLE:
  - arm_i -> PRE.
- PRE (must see the inactive level first, so a line already active at arm does not fire):
  - sig_q=0 -> ARMED.
- ARMED:
  - sig_q=1 -> QUAL with qcnt=1.
  - If latched qual_len<=1, fire immediately instead (see trigger).
- QUAL:
  - sig_q=1: qcnt+1.
  - sig_q=0: -> ARMED, qcnt=0.
  - Reaching qcnt==qual_len fires the trigger.
- Trigger:
  - trig_o=1 for exactly one cycle, rising at edge t0+qual_len (qual_len=0 behaves as 1). Example: qual_len=12 gives a pulse at t0+12.
  - trig_cnt_o increments on the same edge and saturates at all-ones.
  - Next state:
    - continuous with holdoff>0 -> HOLDOFF.
    - continuous with holdoff=0 -> PRE.
    - single -> IDLE.
- HOLDOFF:
  - hcnt counts 1..holdoff, ignoring sig_q. After holdoff cycles -> PRE.
  - A line still active after holdoff therefore never retriggers until it goes inactive.
- Priority at each edge: reset > disarm_i > arm_i > FSM transition.
  - disarm_i in any state -> IDLE. A trig_o that would fire on that same edge is suppressed.
  - arm_i outside IDLE is ignored: no re-latch, no restart.
  - arm_i and disarm_i together -> IDLE.
- clr_cnt_i: trig_cnt_o=0 next edge. If a trigger fires on the same edge, the result is 1.
- Counters: qcnt and hcnt are CNT_W wide and compare with ==. qual_len=all-ones is legal, with no wrap.
- Reset mid-QUAL or mid-HOLDOFF: abort to IDLE, no trig_o.

Decomposition:
- Shared package (edge_trig_pkg): state encoding localparams (IDLE..HOLDOFF) and default CNT_W/TCNT_W. The register bank decodes state_o from the same constants.
- One natural sub-module: edge_trig_qual, the input register plus qualification counter, exposing sig_q and a qualified-hit strobe.
- FSM, holdoff counter and event counter remain in edge_trig_ctrl.

Test Plan:
- Falling edge, single shot: pol=0, qual=12, mode=0, arm with sig_i high, then sig_i low from t0 held 20 cycles -> one trig_o at t0+12, trig_cnt_o=1, state IDLE, armed_o=0.
- Glitch rejection: qual=12, low pulses of 5 and 11 cycles, then a 12-cycle low pulse -> exactly one trig_o, at t0(3rd pulse)+12.
- Line already active at arm: sig_i held low, arm -> no trigger. sig_i high 1 cycle then low at t0 -> trig_o at t0+qual.
- Continuous with holdoff: mode=1, qual=2, holdoff=10, sig_i toggling low 3 / high 1 cycles.
  - Triggers are separated by at least 10 holdoff cycles plus re-qualification.
  - trig_cnt_o matches the pulse count.
- Boundaries:
  - qual_len=0 -> fires at t0+1.
  - disarm_i on the firing edge -> no trig_o, state IDLE.
  - arm_i+disarm_i together -> IDLE.
  - trig_cnt_o preloaded near max via TCNT_W=4 -> saturates at 15.
  - clr_cnt_i on a trigger edge -> 1.
- Reset: assert rstn_i=0 for 1 cycle mid-QUAL and mid-HOLDOFF -> all outputs 0 next edge, no trig_o. Re-arm works normally.
